mem_initiator: RTL

MEM_INITIATOR -- requirements
Module: mem_initiator

---
 rtl/mem_initiator_if.sv | 32 +++
 rtl/mem_initiator.sv | 123 ++++++++++++
 2 files changed

// File: rtl/mem_initiator_if.sv
// mem_initiator_if: command, write/read data streams and memory bus of mem_initiator
interface mem_initiator_if #(
   parameter int WIDTH      = 16,
   parameter int ADDR_WIDTH = 6
);
   logic                  cmd_valid_i;
   logic                  cmd_ready_o;
   logic                  cmd_wr_i;
   logic [ADDR_WIDTH-1:0] cmd_addr_i;
   logic [ADDR_WIDTH:0]   cmd_len_i;
   logic [WIDTH-1:0]      wr_data_i;
   logic                  wr_valid_i;
   logic                  wr_ready_o;
   logic [WIDTH-1:0]      rd_data_o;
   logic                  rd_valid_o;
   logic                  done_o;
   logic                  err_o;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic [WIDTH-1:0]      mem_wdata_o;
   logic                  mem_wr_rd_o;
   logic                  mem_valid_o;
   logic [WIDTH-1:0]      mem_rdata_i;
   logic                  mem_ready_i;
   modport master (
      input  cmd_valid_i, cmd_wr_i, cmd_addr_i, cmd_len_i, wr_data_i, wr_valid_i, mem_rdata_i, mem_ready_i,
      output cmd_ready_o, wr_ready_o, rd_data_o, rd_valid_o, done_o, err_o, mem_addr_o, mem_wdata_o, mem_wr_rd_o, mem_valid_o
   );
   modport slave (
      output cmd_valid_i, cmd_wr_i, cmd_addr_i, cmd_len_i, wr_data_i, wr_valid_i, mem_rdata_i, mem_ready_i,
      input  cmd_ready_o, wr_ready_o, rd_data_o, rd_valid_o, done_o, err_o, mem_addr_o, mem_wdata_o, mem_wr_rd_o, mem_valid_o
   );
endinterface

// File: rtl/mem_initiator.sv
// mem_initiator: burst read/write initiator with per-word GAP handshake and REQ watchdog
module mem_initiator #(
   parameter int WIDTH      = 16,
   parameter int ADDR_WIDTH = 6,
   parameter int TIMEOUT    = 15
) (
   input logic             clk_i,
   input logic             rst_i,
   mem_initiator_if.master bus
);
   localparam int WDW = $clog2(TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, FETCH, REQ, GAP, DONE} state_t;
   state_t                r_state;
   logic                  r_cmd_ready;
   logic                  r_wr_ready;
   logic                  r_mem_valid;
   logic                  r_mem_wr_rd;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [WIDTH-1:0]      r_mem_wdata;
   logic [WIDTH-1:0]      r_rd_data;
   logic                  r_rd_valid;
   logic                  r_done;
   logic                  r_err;
   logic                  r_abort;
   logic [ADDR_WIDTH:0]   r_rem;
   logic [WDW-1:0]        r_wd;
   assign bus.cmd_ready_o = r_cmd_ready;
   assign bus.wr_ready_o  = r_wr_ready;
   assign bus.mem_valid_o = r_mem_valid;
   assign bus.mem_wr_rd_o = r_mem_wr_rd;
   assign bus.mem_addr_o  = r_mem_addr;
   assign bus.mem_wdata_o = r_mem_wdata;
   assign bus.rd_data_o   = r_rd_data;
   assign bus.rd_valid_o  = r_rd_valid;
   assign bus.done_o      = r_done;
   assign bus.err_o       = r_err;
   // Outputs are set on the transition into each state; done/err trail the DONE state by one cycle.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state     <= IDLE;
         r_cmd_ready <= 1'b1;
         r_wr_ready  <= 1'b0;
         r_mem_valid <= 1'b0;
         r_mem_wr_rd <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_rd_data   <= '0;
         r_rd_valid  <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_abort     <= 1'b0;
         r_rem       <= '0;
         r_wd        <= '0;
      end else begin
         r_rd_valid <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         case (r_state)
            IDLE: if (bus.cmd_valid_i) begin
               r_cmd_ready <= 1'b0;
               r_mem_wr_rd <= bus.cmd_wr_i;
               r_mem_addr  <= bus.cmd_addr_i;
               r_rem       <= bus.cmd_len_i;
               r_abort     <= 1'b0;
               if (bus.cmd_len_i == '0) begin
                  r_state <= DONE;
               end else if (bus.cmd_wr_i) begin
                  r_state    <= FETCH;
                  r_wr_ready <= 1'b1;
               end else begin
                  r_state     <= REQ;
                  r_mem_valid <= 1'b1;
                  r_wd        <= '0;
               end
            end
            FETCH: if (bus.wr_valid_i) begin
               r_mem_wdata <= bus.wr_data_i;
               r_wr_ready  <= 1'b0;
               r_mem_valid <= 1'b1;
               r_wd        <= '0;
               r_state     <= REQ;
            end
            REQ: if (bus.mem_ready_i) begin
               r_mem_valid <= 1'b0;
               r_state     <= GAP;
               if (!r_mem_wr_rd) begin
                  r_rd_data  <= bus.mem_rdata_i;
                  r_rd_valid <= 1'b1;
               end
            end else if (r_wd == WDW'(TIMEOUT - 1)) begin
               r_mem_valid <= 1'b0;
               r_abort     <= 1'b1;
               r_state     <= DONE;
            end else begin
               r_wd <= r_wd + 1'b1;
            end
            GAP: if (!bus.mem_ready_i) begin
               if (r_rem == (ADDR_WIDTH+1)'(1)) begin
                  r_state <= DONE;
               end else begin
                  r_rem      <= r_rem - 1'b1;
                  r_mem_addr <= r_mem_addr + 1'b1;
                  if (r_mem_wr_rd) begin
                     r_state    <= FETCH;
                     r_wr_ready <= 1'b1;
                  end else begin
                     r_state     <= REQ;
                     r_mem_valid <= 1'b1;
                     r_wd        <= '0;
                  end
               end
            end
            DONE: begin
               r_done      <= 1'b1;
               r_err       <= r_abort;
               r_cmd_ready <= 1'b1;
               r_state     <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
